puf_challenge_ctrl: RTL and testbench

Sequencer for the arbiter-PUF array. On a start request it expands a 16-bit seed into a stream of CHAL_W-bit challenges, applies each to the PUF, waits a fixed settle time, and samples the 1-bit PUF response. It packs RESP_BITS samples into one response word and hands that word to the key/ID logic over a valid/ready handshake. It sits between the PUF instance (challenge out, response in) and the downstream consumer.

---
 rtl/puf_ctrl_pkg.sv | 25 ++
 rtl/puf_challenge_ctrl_if.sv | 22 ++
 rtl/puf_lfsr16.sv | 34 +++
 rtl/puf_challenge_ctrl.sv | 174 +++++++++++++++++
 tb/tb_puf_challenge_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/puf_ctrl_pkg.sv
// Shared types and LFSR constants for the PUF challenge sequencer.
package puf_ctrl_pkg;

  localparam int unsigned LFSR_W = 16;

  // Feedback taps: bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'h0001;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_e;

  // An all-zero seed would lock the LFSR, so it is replaced.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? LFSR_ZERO_SUB : seed;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_challenge_ctrl_if.sv
// Response hand-off bus from the PUF sequencer to the key/ID consumer.
interface puf_challenge_ctrl_if #(
  parameter int unsigned RESP_BITS = 32
);

  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_ready;

  modport master (
    output resp_data,
    output resp_valid,
    input  resp_ready
  );

  modport slave (
    input  resp_data,
    input  resp_valid,
    output resp_ready
  );

endinterface

// File: rtl/puf_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load (zero-substituted) and single-step advance.
module puf_lfsr16
  import puf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = lfsr_seed(seed_i);
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_ZERO_SUB;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF sequencer: applies LFSR challenges, samples responses, packs a word.
// Optional majority vote per challenge when PUF_MAJORITY_VOTE_EN is defined.
module puf_challenge_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int unsigned CHAL_W    = 4,
  parameter int unsigned RESP_BITS = 32,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned VOTES     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [LFSR_W-1:0]   seed_i,
  output logic [CHAL_W-1:0]   challenge_o,
  input  logic                puf_resp_i,
  output logic                busy_o,
  puf_challenge_ctrl_if.master resp_if
);

  localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (CHAL_W == 0 || CHAL_W > LFSR_W || RESP_BITS == 0 || RESP_BITS > 64 ||
      SETTLE == 0 || VOTES < 3 || (VOTES % 2) == 0) begin : g_param_check
    $error("puf_challenge_ctrl: illegal parameter set");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAL_W-1:0]    challenge_q, challenge_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic                 lfsr_load, lfsr_step;
  logic [LFSR_W-1:0]    lfsr_state;
  logic                 settle_end;
  logic                 sample, sample_bit;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned VOTE_W = $clog2(VOTES + 1);
  localparam int unsigned VIDX_W = $clog2(VOTES);

  logic [VIDX_W-1:0] vote_q, vote_d;
  logic [VOTE_W-1:0] ones_q, ones_d;
  logic [VOTE_W-1:0] ones_sum;
`endif

  puf_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (seed_i),
    .state_o (lfsr_state)
  );

  assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    challenge_d = challenge_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    sample      = 1'b0;
    sample_bit  = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
    vote_d      = vote_q;
    ones_d      = ones_q;
    ones_sum    = ones_q + VOTE_W'(puf_resp_i);
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = APPLY;
          lfsr_load   = 1'b1;
          challenge_d = CHAL_W'(lfsr_seed(seed_i));
          idx_d       = '0;
          cnt_d       = '0;
          data_d      = '0;
          busy_d      = 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
          vote_d      = '0;
          ones_d      = '0;
`endif
        end
      end

      APPLY: begin
        cnt_d = settle_end ? '0 : cnt_q + CNT_W'(1);
        if (settle_end) begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (vote_q == VIDX_W'(VOTES - 1)) begin
            sample     = 1'b1;
            sample_bit = (ones_sum > VOTE_W'(VOTES / 2));
            vote_d     = '0;
            ones_d     = '0;
          end else begin
            vote_d     = vote_q + VIDX_W'(1);
            ones_d     = ones_sum;
          end
`else
          sample     = 1'b1;
          sample_bit = puf_resp_i;
`endif
        end
        if (sample) begin
          data_d[idx_q] = sample_bit;
          lfsr_step     = 1'b1;
          challenge_d   = CHAL_W'(lfsr_next(lfsr_state));
          if (idx_q == IDX_W'(RESP_BITS - 1)) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        if (resp_if.resp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      challenge_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_q      <= '0;
      ones_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      challenge_q <= challenge_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
`ifdef PUF_MAJORITY_VOTE_EN
      vote_q      <= vote_d;
      ones_q      <= ones_d;
`endif
    end
  end

  assign challenge_o        = challenge_q;
  assign busy_o             = busy_q;
  assign resp_if.resp_data  = data_q;
  assign resp_if.resp_valid = valid_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Randomized self-checking bench for puf_challenge_ctrl against a behavioural model.
module tb_puf_challenge_ctrl;

  localparam int unsigned CHAL_W    = 4;
  localparam int unsigned RESP_BITS = 8;
  localparam int unsigned SETTLE    = 2;
  localparam int unsigned VOTES     = 3;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned NV = VOTES;
`else
  localparam int unsigned NV = 1;
`endif
  localparam int unsigned WIN = SETTLE * NV;
  localparam int unsigned LAT = RESP_BITS * WIN + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       seed;
  logic [CHAL_W-1:0] challenge;
  logic              puf_resp;
  logic              busy;

  int total = 0;
  int bad   = 0;

  puf_challenge_ctrl_if #(.RESP_BITS(RESP_BITS)) rif ();

  puf_challenge_ctrl #(
    .CHAL_W    (CHAL_W),
    .RESP_BITS (RESP_BITS),
    .SETTLE    (SETTLE),
    .VOTES     (VOTES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .seed_i      (seed),
    .challenge_o (challenge),
    .puf_resp_i  (puf_resp),
    .busy_o      (busy),
    .resp_if     (rif)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference LFSR step from the polynomial, plain integer arithmetic.
  function automatic int unsigned model_step(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l * 2) + fb) % 65536;
  endfunction

  // mode 0: resp=1, 1: resp=|challenge, 2: random, 3: pattern 1,0,1 per vote window
  task automatic run_txn(input logic [15:0] s, input int mode, input int wait_n,
                         input bit poke, input int rst_cyc);
    int unsigned          st;
    logic [CHAL_W-1:0]    ce[RESP_BITS+1];
    logic                 drv[LAT+1];
    logic [RESP_BITS-1:0] exp_d;
    int                   ones;
    int                   kk;

    st = (s == 16'h0000) ? 1 : int'(s);
    for (int k = 0; k <= RESP_BITS; k++) begin
      ce[k] = CHAL_W'(st % (1 << CHAL_W));
      st    = model_step(st);
    end
    for (int c = 0; c <= LAT; c++) drv[c] = 1'b0;

    rif.resp_ready = (wait_n == 0);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = 16'($urandom);

    for (int c = 1; c < LAT; c++) begin
      kk = (c - 1) / WIN;
      chk_eq("apply_chal", 64'(challenge), 64'(ce[kk]));
      chk_eq("apply_busy", 64'(busy), 64'd1);
      chk_eq("apply_valid", 64'(rif.resp_valid), 64'd0);
      case (mode)
        0:       puf_resp = 1'b1;
        1:       puf_resp = |challenge;
        2:       puf_resp = 1'($urandom % 2);
        default: puf_resp = ((((c - 1) / SETTLE) % NV) % 2) == 0;
      endcase
      drv[c] = puf_resp;
      start  = poke && (c == 2);
      if (c == rst_cyc) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk_eq("rst_chal", 64'(challenge), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_valid", 64'(rif.resp_valid), 64'd0);
        chk_eq("rst_data", 64'(rif.resp_data), 64'd0);
        return;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    for (int k = 0; k < RESP_BITS; k++) begin
      if (mode == 1) begin
        exp_d[k] = |ce[k];
      end else begin
        ones = 0;
        for (int v = 0; v < NV; v++) ones += int'(drv[(k * NV + v + 1) * SETTLE]);
        exp_d[k] = (ones * 2 > NV);
      end
    end

    chk_eq("done_valid", 64'(rif.resp_valid), 64'd1);
    chk_eq("done_data", 64'(rif.resp_data), 64'(exp_d));
    chk_eq("done_busy", 64'(busy), 64'd1);
    chk_eq("done_chal", 64'(challenge), 64'(ce[RESP_BITS]));

    for (int w = 0; w < wait_n; w++) begin
      rif.resp_ready = 1'b0;
      start = poke && (w == 1);
      puf_resp = 1'($urandom % 2);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk_eq("hold_valid", 64'(rif.resp_valid), 64'd1);
      chk_eq("hold_data", 64'(rif.resp_data), 64'(exp_d));
      chk_eq("hold_busy", 64'(busy), 64'd1);
    end

    rif.resp_ready = 1'b1;
    start = poke;
    @(posedge clk);
    #1;
    rif.resp_ready = 1'b0;
    start = 1'b0;
    chk_eq("hs_valid", 64'(rif.resp_valid), 64'd0);
    chk_eq("hs_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    seed           = 16'h0000;
    puf_resp       = 1'b0;
    rif.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_chal", 64'(challenge), 64'd0);
    chk_eq("reset_busy", 64'(busy), 64'd0);
    chk_eq("reset_valid", 64'(rif.resp_valid), 64'd0);
    chk_eq("reset_data", 64'(rif.resp_data), 64'd0);
    rst = 1'b0;

    run_txn(16'h0001, 0, 0, 1'b0, 0);
    run_txn(16'h0001, 1, 2, 1'b0, 0);
    run_txn(16'h0000, 1, 1, 1'b0, 0);
    run_txn(16'hACE1, 0, 5, 1'b1, 0);
    run_txn(16'h1234, 2, 0, 1'b0, 3 * WIN + 1);
    run_txn(16'h1234, 2, 3, 1'b0, 0);
    run_txn(16'h0001, 3, 0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      run_txn(16'($urandom), 2, $urandom_range(0, 4), 1'($urandom % 2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
